// File: rtl/eq_pkg.sv
// Shared definitions for the alarm-game puzzle sequencer and its timeout counter.
package eq_pkg;

    // Width of the time/seconds datapath
    localparam int TIME_W = 7;

    // Default engine count and the index width it implies
    localparam int DEF_NUM_EQ = 3;
    localparam int EQ_IDX_W   = $clog2(DEF_NUM_EQ);

    // Default puzzle rules
    localparam int DEF_REQUIRED_PASSES = 2;
    localparam int DEF_MAX_TRIES       = 3;
    localparam int DEF_TIMEOUT_S       = 60;

    // Sequencer state encodings
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SELECT  = 3'd1;
    localparam logic [2:0] ST_ACTIVE  = 3'd2;
    localparam logic [2:0] ST_DROP    = 3'd3;
    localparam logic [2:0] ST_CLEARED = 3'd4;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        SELECT  = ST_SELECT,
        ACTIVE  = ST_ACTIVE,
        DROP    = ST_DROP,
        CLEARED = ST_CLEARED
    } state_t;

endpackage

// File: rtl/eq_timeout_counter.sv
// Per-puzzle seconds countdown: reloads on request, counts down on each
// enabled second tick, sticks at zero and flags it.
module eq_timeout_counter
    import eq_pkg::*;
#(
    parameter logic [TIME_W-1:0] RELOAD = TIME_W'(DEF_TIMEOUT_S)
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              load,
    input  logic              tick,
    output logic [TIME_W-1:0] count,
    output logic              zero
);

    // Reload has priority; otherwise decrement on tick, saturating at zero
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            count <= RELOAD;
        end else if (load) begin
            count <= RELOAD;
        end else if (tick && (count != '0)) begin
            count <= count - TIME_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/equation_sequencer.sv
// Puzzle controller for the alarm game: keeps the buzzer on, hands one
// equation engine at a time a start level, tallies verdicts and timeouts,
// and dismisses the alarm after enough consecutive correct answers.
module equation_sequencer
    import eq_pkg::*;
#(
    parameter int NUM_EQ          = DEF_NUM_EQ,
    parameter int REQUIRED_PASSES = DEF_REQUIRED_PASSES,
    parameter int MAX_TRIES       = DEF_MAX_TRIES,
    parameter int TIMEOUT_S       = DEF_TIMEOUT_S
) (
    input  logic                                 Clock,
    input  logic                                 Resetn,
    input  logic                                 AlarmTrigger,
    input  logic                                 SecTick,
    input  logic [TIME_W-1:0]                    OngoingTimer,
    input  logic [NUM_EQ-1:0]                    resultValid,
    input  logic [NUM_EQ-1:0]                    resultCorrect,
    output logic [NUM_EQ-1:0]                    startEq,
    output logic                                 AlarmOn,
    output logic                                 Cleared,
    output logic [$clog2(NUM_EQ)-1:0]            eqIndex,
    output logic [$clog2(REQUIRED_PASSES+1)-1:0] passCount,
    output logic [$clog2(MAX_TRIES+1)-1:0]       triesLeft,
    output logic [TIME_W-1:0]                    secondsLeft
);

    localparam int IDX_W = $clog2(NUM_EQ);
    localparam int PC_W  = $clog2(REQUIRED_PASSES + 1);
    localparam int TR_W  = $clog2(MAX_TRIES + 1);

    localparam logic [TIME_W-1:0] NUM_EQ_T   = TIME_W'(NUM_EQ);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_EQ - 1);
    localparam logic [PC_W-1:0]   PASS_GOAL  = PC_W'(REQUIRED_PASSES);
    localparam logic [TR_W-1:0]   TRIES_FULL = TR_W'(MAX_TRIES);

    state_t            state;
    logic [IDX_W-1:0]  lastIndex;
    logic [IDX_W-1:0]  base_index;
    logic [IDX_W-1:0]  sel_index;
    logic [NUM_EQ-1:0] sel_onehot;
    logic [PC_W-1:0]   pass_next;
    logic              verdict_hit;
    logic              verdict_ok;
    logic              timeout_zero;
    logic              timer_load;
    logic              timer_tick;

    // Seed-based pick; after a pass, never hand the same engine out twice running
    always_comb begin
        base_index = IDX_W'(OngoingTimer % NUM_EQ_T);
        sel_index  = base_index;
        if ((passCount != '0) && (base_index == lastIndex)) begin
            sel_index = (base_index == LAST_IDX) ? '0 : base_index + IDX_W'(1);
        end
    end

    // One-hot start pattern for the engine being selected
    genvar gi;
    generate
        for (gi = 0; gi < NUM_EQ; gi++) begin : g_sel_onehot
            assign sel_onehot[gi] = (sel_index == IDX_W'(gi));
        end
    endgenerate

    // startEq is one-hot of eqIndex during ACTIVE, so it masks out other engines' verdicts
    assign verdict_hit = |(resultValid & startEq);
    assign verdict_ok  = |(resultValid & resultCorrect & startEq);
    assign pass_next   = passCount + PC_W'(1);

    assign timer_load = (state == SELECT);
    assign timer_tick = (state == ACTIVE) && SecTick;

    eq_timeout_counter #(
        .RELOAD (TIME_W'(TIMEOUT_S))
    ) u_timeout (
        .Clock  (Clock),
        .Resetn (Resetn),
        .load   (timer_load),
        .tick   (timer_tick),
        .count  (secondsLeft),
        .zero   (timeout_zero)
    );

    // Puzzle sequencing FSM with registered outputs
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state     <= IDLE;
            startEq   <= '0;
            AlarmOn   <= 1'b0;
            Cleared   <= 1'b0;
            eqIndex   <= '0;
            lastIndex <= '0;
            passCount <= '0;
            triesLeft <= TRIES_FULL;
        end else begin
            Cleared <= 1'b0;
            case (state)
                IDLE: begin
                    if (AlarmTrigger) begin
                        state   <= SELECT;
                        AlarmOn <= 1'b1;
                    end
                end
                SELECT: begin
                    eqIndex <= sel_index;
                    startEq <= sel_onehot;
                    state   <= ACTIVE;
                end
                ACTIVE: begin
                    if (verdict_hit) begin
                        startEq <= '0;
                        if (verdict_ok) begin
                            passCount <= pass_next;
                            lastIndex <= eqIndex;
                            if (pass_next == PASS_GOAL) begin
                                state   <= CLEARED;
                                AlarmOn <= 1'b0;
                                Cleared <= 1'b1;
                            end else begin
                                state <= DROP;
                            end
                        end else begin
                            state <= DROP;
                            if (triesLeft == TR_W'(1)) begin
                                passCount <= '0;
                                triesLeft <= TRIES_FULL;
                            end else begin
                                triesLeft <= triesLeft - TR_W'(1);
                            end
                        end
                    end else if (timeout_zero) begin
                        // An expired puzzle is scored exactly like a wrong answer
                        startEq <= '0;
                        state   <= DROP;
                        if (triesLeft == TR_W'(1)) begin
                            passCount <= '0;
                            triesLeft <= TRIES_FULL;
                        end else begin
                            triesLeft <= triesLeft - TR_W'(1);
                        end
                    end
                end
                DROP: begin
                    state <= SELECT;
                end
                CLEARED: begin
                    if (!AlarmTrigger) begin
                        state     <= IDLE;
                        passCount <= '0;
                        triesLeft <= TRIES_FULL;
                    end
                end
                default: begin
                    state   <= IDLE;
                    startEq <= '0;
                    AlarmOn <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_equation_sequencer.sv
// Scoreboard bench for equation_sequencer: stimulus queues the expected
// snapshot for every puzzle start and alarm clear; a negedge monitor pops
// and compares whenever the DUT raises startEq or pulses Cleared.
module tb_equation_sequencer;

    logic       Clock = 1'b0;
    logic       Resetn = 1'b0;
    logic       AlarmTrigger = 1'b0;
    logic       SecTick = 1'b0;
    logic [6:0] OngoingTimer = 7'd0;
    logic [2:0] resultValid = 3'b000;
    logic [2:0] resultCorrect = 3'b000;
    logic [2:0] startEq;
    logic       AlarmOn;
    logic       Cleared;
    logic [1:0] eqIndex;
    logic [1:0] passCount;
    logic [1:0] triesLeft;
    logic [6:0] secondsLeft;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int kind;   // 0 = puzzle start, 1 = alarm cleared
        int oh;
        int idx;
        int pass;
        int tries;
        int secs;
        int alarm;
    } exp_t;

    exp_t       exp_q[$];
    logic [2:0] prev_start = 3'b000;

    equation_sequencer dut (
        .Clock         (Clock),
        .Resetn        (Resetn),
        .AlarmTrigger  (AlarmTrigger),
        .SecTick       (SecTick),
        .OngoingTimer  (OngoingTimer),
        .resultValid   (resultValid),
        .resultCorrect (resultCorrect),
        .startEq       (startEq),
        .AlarmOn       (AlarmOn),
        .Cleared       (Cleared),
        .eqIndex       (eqIndex),
        .passCount     (passCount),
        .triesLeft     (triesLeft),
        .secondsLeft   (secondsLeft)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end else begin
            $display("[TB] ok %s = %0d", name, act);
        end
    endtask

    task automatic push_start(input int oh, input int idx, input int pass, input int tries);
        exp_t e;
        e = '{0, oh, idx, pass, tries, 60, 1};
        exp_q.push_back(e);
    endtask

    task automatic push_clear(input int pass, input int tries);
        exp_t e;
        e = '{1, 0, 0, pass, tries, 0, 0};
        exp_q.push_back(e);
    endtask

    task automatic check_event(input int kind);
        exp_t e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_event: got kind %0d startEq %0d, expected no event", kind, startEq);
        end else begin
            e = exp_q.pop_front();
            $display("[TB] event kind=%0d startEq=%b eqIndex=%0d pass=%0d tries=%0d secs=%0d alarm=%0d",
                     kind, startEq, eqIndex, passCount, triesLeft, secondsLeft, AlarmOn);
            chk("ev_kind", kind, e.kind);
            chk("ev_startEq", int'(startEq), e.oh);
            if (kind == 0) begin
                chk("ev_eqIndex", int'(eqIndex), e.idx);
                chk("ev_secondsLeft", int'(secondsLeft), e.secs);
            end
            chk("ev_passCount", int'(passCount), e.pass);
            chk("ev_triesLeft", int'(triesLeft), e.tries);
            chk("ev_AlarmOn", int'(AlarmOn), e.alarm);
        end
    endtask

    // Monitor: compare on every new puzzle start and every Cleared pulse
    always @(negedge Clock) begin
        if (Resetn) begin
            if ((startEq != 3'b000) && (prev_start == 3'b000)) check_event(0);
            if (Cleared) check_event(1);
        end
        prev_start <= startEq;
    end

    // Wait (bounded) for the next puzzle start, ending on that negedge
    task automatic wait_start();
        bit found;
        found = 1'b0;
        for (int n = 0; n < 30 && !found; n++) begin
            @(negedge Clock);
            if (startEq != 3'b000) found = 1'b1;
        end
        if (!found) begin
            tests++;
            fails++;
            $display("FAIL wait_start: got startEq %b after 30 cycles, expected a start", startEq);
        end
    endtask

    // One-cycle verdict strobe driven from a negedge
    task automatic verdict(input logic [2:0] oh, input bit correct);
        resultValid   = oh;
        resultCorrect = correct ? oh : 3'b000;
        @(negedge Clock);
        resultValid   = 3'b000;
        resultCorrect = 3'b000;
    endtask

    // n SecTick pulses; returns on the negedge right after the last decrement
    task automatic sec_ticks(input int n);
        repeat (n) begin
            @(negedge Clock);
            SecTick = 1'b1;
            @(negedge Clock);
            SecTick = 1'b0;
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge Clock);
        chk("rst_startEq", int'(startEq), 0);
        chk("rst_AlarmOn", int'(AlarmOn), 0);
        chk("rst_Cleared", int'(Cleared), 0);
        chk("rst_eqIndex", int'(eqIndex), 0);
        chk("rst_passCount", int'(passCount), 0);
        chk("rst_triesLeft", int'(triesLeft), 3);
        chk("rst_secondsLeft", int'(secondsLeft), 60);

        // Round 1: seed 4 -> engine 1, then repeat avoided -> engine 2, clear
        Resetn       = 1'b1;
        OngoingTimer = 7'd4;
        AlarmTrigger = 1'b1;
        push_start(3'b010, 1, 0, 3);
        @(negedge Clock);
        chk("r1_alarm_on", int'(AlarmOn), 1);
        chk("r1_select_no_start", int'(startEq), 0);
        wait_start();
        push_start(3'b100, 2, 1, 3);
        verdict(3'b010, 1'b1);
        chk("r1_drop_startEq", int'(startEq), 0);
        chk("r1_pass1", int'(passCount), 1);
        wait_start();
        push_clear(2, 3);
        verdict(3'b100, 1'b1);
        chk("r1_cleared_startEq", int'(startEq), 0);
        repeat (3) @(negedge Clock);
        chk("r1_hold_Cleared", int'(Cleared), 0);
        chk("r1_hold_AlarmOn", int'(AlarmOn), 0);
        chk("r1_hold_pass", int'(passCount), 2);
        AlarmTrigger = 1'b0;
        repeat (2) @(negedge Clock);
        chk("r1_idle_pass", int'(passCount), 0);
        chk("r1_idle_tries", int'(triesLeft), 3);
        chk("r1_idle_AlarmOn", int'(AlarmOn), 0);

        // Round 2: one pass, then three wrong answers exhaust the tries
        OngoingTimer = 7'd0;
        AlarmTrigger = 1'b1;
        push_start(3'b001, 0, 0, 3);
        wait_start();
        AlarmTrigger = 1'b0;    // falling trigger must not cancel the puzzle
        push_start(3'b010, 1, 1, 3);
        verdict(3'b001, 1'b1);
        chk("r2_drop0_startEq", int'(startEq), 0);
        wait_start();
        push_start(3'b010, 1, 1, 2);
        verdict(3'b010, 1'b0);
        chk("r2_drop1_startEq", int'(startEq), 0);
        chk("r2_tries_2", int'(triesLeft), 2);
        wait_start();
        push_start(3'b010, 1, 1, 1);
        verdict(3'b010, 1'b0);
        chk("r2_drop2_startEq", int'(startEq), 0);
        chk("r2_tries_1", int'(triesLeft), 1);
        wait_start();
        push_start(3'b001, 0, 0, 3);
        verdict(3'b010, 1'b0);
        chk("r2_drop3_startEq", int'(startEq), 0);
        chk("r2_tries_reload", int'(triesLeft), 3);
        chk("r2_pass_zero", int'(passCount), 0);
        wait_start();

        // Verdict from a non-selected engine is ignored
        resultValid   = 3'b100;
        resultCorrect = 3'b100;
        @(negedge Clock);
        resultValid   = 3'b000;
        resultCorrect = 3'b000;
        chk("ign_startEq", int'(startEq), 1);
        chk("ign_pass", int'(passCount), 0);
        chk("ign_tries", int'(triesLeft), 3);
        @(negedge Clock);
        chk("ign_still_active", int'(startEq), 1);

        // Timeout: 60 ticks, then counted as a wrong answer
        OngoingTimer = 7'd5;
        sec_ticks(60);
        chk("to_seconds_zero", int'(secondsLeft), 0);
        chk("to_still_active", int'(startEq), 1);
        chk("to_tries_before", int'(triesLeft), 3);
        push_start(3'b100, 2, 0, 2);
        wait_start();

        // Correct verdict in the same cycle as timeout: verdict wins
        sec_ticks(60);
        chk("race_seconds_zero", int'(secondsLeft), 0);
        push_start(3'b001, 0, 1, 2);
        verdict(3'b100, 1'b1);
        chk("race_pass", int'(passCount), 1);
        chk("race_tries", int'(triesLeft), 2);
        wait_start();

        // Asynchronous reset mid-ACTIVE
        @(negedge Clock);
        #2 Resetn = 1'b0;
        #1;
        chk("arst_startEq", int'(startEq), 0);
        chk("arst_AlarmOn", int'(AlarmOn), 0);
        chk("arst_Cleared", int'(Cleared), 0);
        chk("arst_pass", int'(passCount), 0);
        chk("arst_tries", int'(triesLeft), 3);
        chk("arst_seconds", int'(secondsLeft), 60);
        @(negedge Clock);
        Resetn = 1'b1;
        repeat (5) @(negedge Clock);
        chk("post_rst_startEq", int'(startEq), 0);
        chk("post_rst_AlarmOn", int'(AlarmOn), 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
